// File: rtl/regfile_wb_pkg.sv
// Shared constants for the Y86 register file: word width, register-ID encodings.
// Latency: n/a (constants and one pure helper function only).
// Backpressure: n/a.

`ifndef WORD
`define WORD [31:0]
`endif
`ifndef RESP
`define RESP 4'h4
`endif
`ifndef RNONE
`define RNONE 4'hf
`endif

package regfile_wb_pkg;

  localparam int         WORD_W   = 32;
  localparam logic [3:0] RESP_ID  = `RESP;
  localparam logic [3:0] RNONE_ID = `RNONE;

  // True when a 4-bit register ID names a real architectural register.
  function automatic logic id_in_range(input logic [3:0] id, input int nreg);
    return ({28'd0, id} < nreg);
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// Raw NREG x WORD storage: two write ports (M beats E on same address), two async read ports.
// Latency: writes land on the rising edge; reads are combinational from stored contents.
// Backpressure: none; callers gate the write enables.

module regfile_bank
  import regfile_wb_pkg::*;
#(
  parameter int                NREG      = 8,
  parameter logic [WORD_W-1:0] ESP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we_e,
  input  logic [3:0]        i_addr_e,
  input  logic [WORD_W-1:0] i_dat_e,
  input  logic              i_we_m,
  input  logic [3:0]        i_addr_m,
  input  logic [WORD_W-1:0] i_dat_m,
  input  logic [3:0]        i_raddr_a,
  input  logic [3:0]        i_raddr_b,
  output logic [WORD_W-1:0] o_rdat_a,
  output logic [WORD_W-1:0] o_rdat_b
);

  logic [WORD_W-1:0] r_regs [NREG];

  // Commit writes; on a shared address the M port overwrites the E port value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (4'(i) == RESP_ID) ? ESP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_we_m && (i_addr_m == 4'(i))) begin
          r_regs[i] <= i_dat_m;
        end else if (i_we_e && (i_addr_e == 4'(i))) begin
          r_regs[i] <= i_dat_e;
        end
      end
    end
  end

  // Decode reads by compare so that IDs beyond the array return zero.
  always_comb begin
    o_rdat_a = '0;
    o_rdat_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_raddr_a == 4'(i)) o_rdat_a = r_regs[i];
      if (i_raddr_b == 4'(i)) o_rdat_b = r_regs[i];
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Y86 register file with write-back commit, write-through bypass, commit counter and bad-dest flag.
// Latency: writes commit on the rising edge; reads are zero-cycle and see same-cycle writes.
// Backpressure: wb_stall=1 suppresses writes, counting and bypass for that cycle.

module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int                NREG      = 8,
  parameter logic [WORD_W-1:0] ESP_RESET = 32'h0000_0000,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic [3:0]        wb_dstE,
  input  logic [WORD_W-1:0] wb_valE,
  input  logic [3:0]        wb_dstM,
  input  logic [WORD_W-1:0] wb_valM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [WORD_W-1:0] d_rvalA,
  output logic [WORD_W-1:0] d_rvalB,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              reg_err
);

  logic              w_commit;
  logic              w_we_e;
  logic              w_we_m;
  logic              w_dup;
  logic              w_bad_dst;
  logic [1:0]        w_inc;
  logic [WORD_W-1:0] w_raw_a;
  logic [WORD_W-1:0] w_raw_b;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_reg_err;

  // Writes (and hence bypass) only happen out of reset and when not stalled.
  assign w_commit  = rst & ~wb_stall;
  assign w_we_e    = w_commit & id_in_range(wb_dstE, NREG);
  assign w_we_m    = w_commit & id_in_range(wb_dstM, NREG);
  // Both ports hitting one register is a single architectural write.
  assign w_dup     = w_we_e & w_we_m & (wb_dstE == wb_dstM);
  assign w_inc     = {1'b0, w_we_e} + {1'b0, w_we_m} - {1'b0, w_dup};
  // RNONE is the legitimate "no write" code; only NREG..14 is an error.
  assign w_bad_dst = w_commit &
                     (((wb_dstE != RNONE_ID) && !id_in_range(wb_dstE, NREG)) ||
                      ((wb_dstM != RNONE_ID) && !id_in_range(wb_dstM, NREG)));

  regfile_bank #(
    .NREG      (NREG),
    .ESP_RESET (ESP_RESET)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_we_e    (w_we_e),
    .i_addr_e  (wb_dstE),
    .i_dat_e   (wb_valE),
    .i_we_m    (w_we_m),
    .i_addr_m  (wb_dstM),
    .i_dat_m   (wb_valM),
    .i_raddr_a (d_srcA),
    .i_raddr_b (d_srcB),
    .o_rdat_a  (w_raw_a),
    .o_rdat_b  (w_raw_b)
  );

  // Read port A: invalid ID reads 0, then M bypass, then E bypass, then stored value.
  always_comb begin
    d_rvalA = w_raw_a;
    if (!id_in_range(d_srcA, NREG))            d_rvalA = '0;
    else if (w_we_m && (d_srcA == wb_dstM))    d_rvalA = wb_valM;
    else if (w_we_e && (d_srcA == wb_dstE))    d_rvalA = wb_valE;
  end

  // Read port B: same priority as port A, fully independent.
  always_comb begin
    d_rvalB = w_raw_b;
    if (!id_in_range(d_srcB, NREG))            d_rvalB = '0;
    else if (w_we_m && (d_srcB == wb_dstM))    d_rvalB = wb_valM;
    else if (w_we_e && (d_srcB == wb_dstE))    d_rvalB = wb_valE;
  end

  // Count distinct registers written (wrapping) and latch any bad destination until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_reg_err <= 1'b0;
    end else begin
      r_wr_cnt <= r_wr_cnt + CNT_W'(w_inc);
      if (w_bad_dst) r_reg_err <= 1'b1;
    end
  end

  assign wr_cnt  = r_wr_cnt;
  assign reg_err = r_reg_err;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus pushes expectations, a monitor pops and compares.
// Latency: checks sample combinational reads 1 time unit after inputs settle, away from posedge.
// Backpressure: wb_stall exercised directly as a stimulus input.

module tb_regfile_wb;

  localparam int CNT_W = 16;

  typedef struct {
    string       name;
    int          kind;   // 0 rvalA, 1 rvalB, 2 wr_cnt, 3 reg_err
    logic [31:0] exp;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             wb_stall;
  logic [3:0]       wb_dstE;
  logic [31:0]      wb_valE;
  logic [3:0]       wb_dstM;
  logic [31:0]      wb_valM;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [31:0]      d_rvalA;
  logic [31:0]      d_rvalB;
  logic [CNT_W-1:0] wr_cnt;
  logic             reg_err;

  exp_t sb_q[$];
  logic sample_go;
  int   n_checks;
  int   n_pass;

  regfile_wb #(
    .NREG      (8),
    .ESP_RESET (32'h0000_0100),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_stall (wb_stall),
    .wb_dstE  (wb_dstE),
    .wb_valE  (wb_valE),
    .wb_dstM  (wb_dstM),
    .wb_valM  (wb_valM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_rvalA  (d_rvalA),
    .d_rvalB  (d_rvalB),
    .wr_cnt   (wr_cnt),
    .reg_err  (reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever a sample is requested, drain the scoreboard against the DUT outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (sample_go);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = d_rvalA;
          1:       act = d_rvalB;
          2:       act = {16'd0, wr_cnt};
          default: act = {31'd0, reg_err};
        endcase
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
      sample_go = 1'b0;
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then hand the queued expectations to the monitor.
  task automatic sample_now();
    #1;
    sample_go = 1'b1;
    #1;
    if (sample_go || sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL monitor_timeout: pending=%0d expected 0", sb_q.size());
      sb_q.delete();
      sample_go = 1'b0;
    end
  endtask

  task automatic idle();
    wb_stall = 1'b0;
    wb_dstE  = 4'hf;
    wb_valE  = 32'h0;
    wb_dstM  = 4'hf;
    wb_valM  = 32'h0;
    d_srcA   = 4'hf;
    d_srcB   = 4'hf;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sample_go = 1'b0;
    rst       = 1'b0;
    idle();

    // Power-on reset, then dirty some state so the later reset pulse has work to do.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wb_dstE = 4'h0; wb_valE = 32'hDEAD;
    wb_dstM = 4'h4; wb_valM = 32'h77;
    @(negedge clk);
    idle();
    wb_dstE = 4'h9; wb_valE = 32'h1234;
    @(negedge clk);
    idle();
    d_srcA = 4'h0;
    expect_val("pre_reg0", 0, 32'hDEAD);
    expect_val("pre_cnt", 2, 32'd2);
    expect_val("pre_err", 3, 32'd1);
    sample_now();

    // Test 1: mid-cycle async reset, checked before any clock edge; bypass disabled in reset.
    #1;
    rst = 1'b0;
    wb_dstE = 4'h0; wb_valE = 32'h55;
    d_srcA = 4'h4; d_srcB = 4'h0;
    expect_val("rst_esp", 0, 32'h100);
    expect_val("rst_reg0", 1, 32'h0);
    expect_val("rst_cnt", 2, 32'd0);
    expect_val("rst_err", 3, 32'd0);
    sample_now();
    @(negedge clk);
    idle();
    rst = 1'b1;

    // Test 2: E write with same-cycle bypass, then stored.
    @(negedge clk);
    wb_dstE = 4'h0; wb_valE = 32'h5; d_srcA = 4'h0;
    expect_val("wr_bypass", 0, 32'h5);
    expect_val("wr_cnt_before", 2, 32'd0);
    sample_now();
    @(negedge clk);
    idle(); d_srcA = 4'h0;
    expect_val("wr_stored", 0, 32'h5);
    expect_val("wr_cnt_1", 2, 32'd1);
    sample_now();

    // Test 3: E/M collision on %esp, M wins, one write counted.
    @(negedge clk);
    wb_dstE = 4'h4; wb_valE = 32'hAA;
    wb_dstM = 4'h4; wb_valM = 32'hBB;
    d_srcB = 4'h4; d_srcA = 4'h0;
    expect_val("coll_bypass", 1, 32'hBB);
    expect_val("coll_other", 0, 32'h5);
    sample_now();
    @(negedge clk);
    idle(); d_srcB = 4'h4;
    expect_val("coll_stored", 1, 32'hBB);
    expect_val("coll_cnt", 2, 32'd2);
    sample_now();

    // Test 4: dual write to distinct registers.
    @(negedge clk);
    wb_dstE = 4'h1; wb_valE = 32'h7;
    wb_dstM = 4'h2; wb_valM = 32'h9;
    d_srcA = 4'h1; d_srcB = 4'h2;
    expect_val("dual_bypA", 0, 32'h7);
    expect_val("dual_bypB", 1, 32'h9);
    sample_now();
    @(negedge clk);
    idle(); d_srcA = 4'h1; d_srcB = 4'h2;
    expect_val("dual_regA", 0, 32'h7);
    expect_val("dual_regB", 1, 32'h9);
    expect_val("dual_cnt", 2, 32'd4);
    sample_now();

    // Test 5: stall suppresses writes and bypass.
    @(negedge clk);
    wb_stall = 1'b1;
    wb_dstE = 4'h3; wb_valE = 32'h33;
    wb_dstM = 4'h2; wb_valM = 32'h99;
    d_srcA = 4'h3; d_srcB = 4'h2;
    expect_val("stall_nobypA", 0, 32'h0);
    expect_val("stall_nobypB", 1, 32'h9);
    sample_now();
    @(negedge clk);
    idle(); d_srcA = 4'h3; d_srcB = 4'h2;
    expect_val("stall_reg3", 0, 32'h0);
    expect_val("stall_reg2", 1, 32'h9);
    expect_val("stall_cnt", 2, 32'd4);
    expect_val("stall_err", 3, 32'd0);
    sample_now();

    // Same-ID reads on both ports, out-of-range read ID returns zero.
    @(negedge clk);
    wb_dstE = 4'h5; wb_valE = 32'h5555;
    d_srcA = 4'h5; d_srcB = 4'h9;
    expect_val("rd_bypE", 0, 32'h5555);
    expect_val("rd_oor", 1, 32'h0);
    sample_now();
    @(negedge clk);
    idle(); d_srcA = 4'h2; d_srcB = 4'h2;
    expect_val("rd_sameA", 0, 32'h9);
    expect_val("rd_sameB", 1, 32'h9);
    sample_now();

    // Test 6: illegal destination sets sticky error without writing or counting.
    @(negedge clk);
    wb_dstE = 4'h9; wb_valE = 32'h99; d_srcA = 4'h9;
    expect_val("ill_read", 0, 32'h0);
    sample_now();
    @(negedge clk);
    idle();
    expect_val("ill_err", 3, 32'd1);
    expect_val("ill_cnt", 2, 32'd5);
    sample_now();
    @(negedge clk);
    expect_val("ill_sticky", 3, 32'd1);
    sample_now();

    // Counter wrap: 5 + 65531 single writes = 2^16 -> 0.
    for (int i = 0; i < 65531; i++) begin
      @(negedge clk);
      wb_dstE = 4'h6; wb_valE = 32'(i);
    end
    @(negedge clk);
    idle(); d_srcA = 4'h6;
    expect_val("wrap_cnt", 2, 32'd0);
    expect_val("wrap_last", 0, 32'd65530);
    sample_now();
    @(negedge clk);
    wb_dstE = 4'h6; wb_valE = 32'h1;
    @(negedge clk);
    idle();
    expect_val("wrap_cnt_1", 2, 32'd1);
    sample_now();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
